// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider.
// One quotient bit is produced per clock, MSB of the dividend first.
// A zero divisor skips the iteration and reports div_by_zero together with
// done on the accepting edge.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  // The partial remainder carries one extra bit so the shifted value can be
  // compared against the divisor without losing its top bit.
  localparam int RW   = WIDTH + 1;
  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q,  divisor_d;
  logic [RW-1:0]    partRem_q,  partRem_d;
  logic [WIDTH-1:0] quot_q,     quot_d;
  logic [CNTW-1:0]  stepCnt_q,  stepCnt_d;
  logic [WIDTH-1:0] resQ_q,     resQ_d;
  logic [WIDTH-1:0] resR_q,     resR_d;
  logic             dbz_q,      dbz_d;
  logic             done_q,     done_d;

  logic [RW-1:0]    remShift;
  logic [RW-1:0]    remStep;
  logic [WIDTH-1:0] quotStep;
  logic             qBit;

  // One restoring step: bring in the next dividend bit, subtract the
  // divisor when it fits, and record the outcome as the next quotient bit.
  always_comb begin
    remShift = (partRem_q << 1) | RW'(dividend_q[WIDTH-1]);
    qBit     = (remShift >= {1'b0, divisor_q});
    remStep  = qBit ? (remShift - {1'b0, divisor_q}) : remShift;
    quotStep = (quot_q << 1) | WIDTH'(qBit);
  end

  // Next-state and datapath control; everything holds unless a state says otherwise.
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    partRem_d  = partRem_q;
    quot_d     = quot_q;
    stepCnt_d  = stepCnt_q;
    resQ_d     = resQ_q;
    resR_d     = resR_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dividend_d = A;
          divisor_d  = B;
          partRem_d  = '0;
          quot_d     = '0;
          stepCnt_d  = '0;
          dbz_d      = 1'b0;
          if (B == '0) begin
            state_d = DONE;
            resQ_d  = '1;
            resR_d  = A;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        dividend_d = dividend_q << 1;
        partRem_d  = remStep;
        quot_d     = quotStep;
        stepCnt_d  = stepCnt_q + 1'b1;
        if (stepCnt_q == LAST_STEP) begin
          state_d = DONE;
          resQ_d  = quotStep;
          resR_d  = remStep[WIDTH-1:0];
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      partRem_q  <= '0;
      quot_q     <= '0;
      stepCnt_q  <= '0;
      resQ_q     <= '0;
      resR_q     <= '0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      partRem_q  <= partRem_d;
      quot_q     <= quot_d;
      stepCnt_q  <= stepCnt_d;
      resQ_q     <= resQ_d;
      resR_q     <= resR_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = done_q;
  assign Q           = resQ_q;
  assign R           = resR_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (WIDTH=4): a vector table, hand-written
// corner-case sequences and a full sweep against a bench-side model.
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [3:0] Q;
  logic [3:0] R;
  logic       div_by_zero;

  int checksTotal;
  int checksPassed;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] expQ;
    logic [3:0] expR;
    logic       expDbz;
    int         expLat;
    int         expBusy;
  } vector_t;

  vector_t vectors[10];

  seq_divider #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .Q          (Q),
    .R          (R),
    .div_by_zero(div_by_zero)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and keep the tally.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checksTotal++;
    if (actual == expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issue one division and wait (bounded) for done. lat counts edges after
  // the accepting edge until done is seen; busyCyc counts sampled busy cycles.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               output int lat, output int busyCyc);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    lat     = 0;
    busyCyc = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busyCyc++;
    end
  endtask

  // Main test sequence.
  initial begin
    int lat;
    int busyCyc;
    int doneSeen;
    logic [3:0] mq;
    logic [3:0] mr;

    checksTotal  = 0;
    checksPassed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;

    vectors[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0, 4, 4};
    vectors[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4, 4};
    vectors[2] = '{4'd3,  4'd9,  4'd0,  4'd3, 1'b0, 4, 4};
    vectors[3] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4, 4};
    vectors[4] = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1, 0, 0};
    vectors[5] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 4, 4};
    vectors[6] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1, 0, 0};
    vectors[7] = '{4'd14, 4'd3,  4'd4,  4'd2, 1'b0, 4, 4};
    vectors[8] = '{4'd8,  4'd8,  4'd1,  4'd0, 1'b0, 4, 4};
    vectors[9] = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0, 4, 4};

    // Reset state, observed before any clock edge.
    #2;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset Q", Q, 0);
    checkOutput("reset R", R, 0);
    checkOutput("reset dbz", div_by_zero, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vectors[i].a, vectors[i].b, lat, busyCyc);
      checkOutput($sformatf("vec%0d latency", i), lat, vectors[i].expLat);
      checkOutput($sformatf("vec%0d busyCycles", i), busyCyc, vectors[i].expBusy);
      checkOutput($sformatf("vec%0d Q", i), Q, vectors[i].expQ);
      checkOutput($sformatf("vec%0d R", i), R, vectors[i].expR);
      checkOutput($sformatf("vec%0d dbz", i), div_by_zero, vectors[i].expDbz);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d donePulseWidth", i), done, 0);
    end

    // Divide-by-zero results hold in IDLE, then stay frozen through CALC
    // while div_by_zero clears on the accepting edge.
    applyStimulus(4'd7, 4'd0, lat, busyCyc);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleHold dbz", div_by_zero, 1);
    checkOutput("idleHold Q", Q, 15);
    checkOutput("idleHold R", R, 7);
    A     = 4'd13;
    B     = 4'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("calcHold busy", busy, 1);
    checkOutput("calcHold dbz", div_by_zero, 0);
    checkOutput("calcHold Q", Q, 15);
    checkOutput("calcHold R", R, 7);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("calcHold latency", lat, 4);
    checkOutput("calcHold final Q", Q, 3);

    // Start during CALC is ignored and operand changes do not leak in.
    @(posedge clk);
    #1;
    A     = 4'd13;
    B     = 4'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    A     = 4'd2;
    B     = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = 4'd5;
    B     = 4'd3;
    lat   = 2;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("ignoreStart latency", lat, 4);
    checkOutput("ignoreStart Q", Q, 3);
    checkOutput("ignoreStart R", R, 1);

    // Start held while in DONE is accepted immediately (no IDLE cycle).
    A     = 4'd9;
    B     = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("backToBack busy", busy, 1);
    checkOutput("backToBack done", done, 0);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("backToBack latency", lat, 4);
    checkOutput("backToBack Q", Q, 4);
    checkOutput("backToBack R", R, 1);

    // Reset in the second CALC cycle aborts without a done pulse.
    @(posedge clk);
    #1;
    A     = 4'd13;
    B     = 4'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset busy", busy, 0);
    checkOutput("midReset done", done, 0);
    checkOutput("midReset Q", Q, 0);
    checkOutput("midReset R", R, 0);
    checkOutput("midReset dbz", div_by_zero, 0);
    doneSeen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) doneSeen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) doneSeen++;
    end
    checkOutput("midReset donePulses", doneSeen, 0);
    applyStimulus(4'd9, 4'd2, lat, busyCyc);
    checkOutput("afterReset latency", lat, 4);
    checkOutput("afterReset Q", Q, 4);
    checkOutput("afterReset R", R, 1);

    // Exhaustive sweep against the arithmetic model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(4'(a), 4'(b), lat, busyCyc);
        if (b == 0) begin
          mq = 4'd15;
          mr = 4'(a);
        end else begin
          mq = 4'(a / b);
          mr = 4'(a % b);
        end
        checkOutput($sformatf("sweep %0d/%0d Q", a, b), Q, mq);
        checkOutput($sformatf("sweep %0d/%0d R", a, b), R, mr);
        checkOutput($sformatf("sweep %0d/%0d dbz", a, b), div_by_zero, (b == 0) ? 1 : 0);
      end
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
